png_ctrl: RTL and testbench

Frame-level sequencer for the PNG encoder datapath (filter -> fifo -> lz77 -> bs, with adler32 and crc32 side engines).
- Accepts one frame request at a time and validates/latches the frame size.
- Issues the per-stage start pulses in the required order and tracks the stage done events.
- Guards each wait phase with a watchdog and reports a single frame-complete pulse or an error code.
- Replaces the ad-hoc start fan-out and lz77 start delay with one owned controller.

---
 rtl/png_ctrl.sv | 177 +++++++++++++++++
 tb/tb_png_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/png_ctrl.sv
// png_ctrl: frame-level sequencer for the PNG encoder datapath.
// Latches and validates the frame size, fans out the stage start pulses in
// order, tracks stage completion with sticky flags, guards every wait phase
// with a watchdog, and reports either one done pulse or an error code.
module png_ctrl #(
    parameter int                W_WD    = 13,
    parameter int                H_WD    = 13,
    parameter int                W_MAX   = 4096,
    parameter int                TMO_WD  = 24,
    parameter logic [TMO_WD-1:0] TMO_CYC = 24'hFFFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [W_WD-1:0] cfg_w_i,
    input  logic [H_WD-1:0] cfg_h_i,
    input  logic            filter_done_i,
    input  logic            lz77_done_i,
    input  logic            adler32_done_i,
    input  logic            bs_done_i,
    input  logic            crc32_done_i,
    output logic [W_WD-1:0] cfg_w_o,
    output logic [H_WD-1:0] cfg_h_o,
    output logic            filter_start_o,
    output logic            lz77_start_o,
    output logic            adler32_start_o,
    output logic            bs_start_o,
    output logic            crc32_start_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [2:0]      err_code_o,
    output logic [15:0]     frm_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_LAUNCH, S_FILT, S_LZ, S_TAIL, S_DONE, S_ERR
    } state_t;

    localparam logic [2:0] EC_NONE = 3'd0;
    localparam logic [2:0] EC_CFG  = 3'd1;
    localparam logic [2:0] EC_FILT = 3'd2;
    localparam logic [2:0] EC_LZ   = 3'd3;
    localparam logic [2:0] EC_BS   = 3'd4;

    localparam logic [W_WD-1:0]   W_MAX_V = W_WD'(W_MAX);
    // Watchdog fires on the cycle the counter shows its last legal value.
    localparam logic [TMO_WD-1:0] WD_LAST = TMO_CYC - 1'b1;

    state_t            state_q, state_n;
    logic [W_WD-1:0]   cfg_w_q;
    logic [H_WD-1:0]   cfg_h_q;
    logic              start4_q, lz77_start_q, busy_q, done_q, err_q;
    logic [2:0]        err_code_q, code_n;
    logic [15:0]       frm_cnt_q;
    logic [TMO_WD-1:0] wd_q;
    logic              lz_flag_q, bs_flag_q, adler_flag_q, crc_flag_q;

    logic cfg_bad, wd_hit, lz_seen, bs_seen, any_done, in_wait, in_run;

    assign cfg_bad  = (cfg_w_q == '0) || (cfg_h_q == '0) || (cfg_w_q > W_MAX_V);
    assign wd_hit   = (wd_q == WD_LAST);
    // Sticky flag or same-cycle pulse both count as "seen".
    assign lz_seen  = lz_flag_q | lz77_done_i;
    assign bs_seen  = bs_flag_q | bs_done_i;
    assign any_done = filter_done_i | lz77_done_i | adler32_done_i | bs_done_i | crc32_done_i;
    assign in_wait  = (state_q == S_FILT) || (state_q == S_LZ) || (state_q == S_TAIL);
    assign in_run   = (state_q == S_CHK) || (state_q == S_LAUNCH) || in_wait;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_n;
    end

    // Next-state and error-code selection; abort overrides any done event.
    always_comb begin
        state_n = state_q;
        code_n  = EC_NONE;
        case (state_q)
            S_IDLE:   if (start_i) state_n = S_CHK;
            S_CHK: begin
                code_n  = EC_CFG;
                state_n = cfg_bad ? S_ERR : S_LAUNCH;
            end
            S_LAUNCH: state_n = S_FILT;
            S_FILT: begin
                code_n = EC_FILT;
                if (filter_done_i)  state_n = S_LZ;
                else if (wd_hit)    state_n = S_ERR;
            end
            S_LZ: begin
                // bs may already be in: skip TAIL and finish straight away.
                code_n = EC_LZ;
                if (lz_seen)        state_n = bs_seen ? S_DONE : S_TAIL;
                else if (wd_hit)    state_n = S_ERR;
            end
            S_TAIL: begin
                code_n = EC_BS;
                if (bs_seen)        state_n = S_DONE;
                else if (wd_hit)    state_n = S_ERR;
            end
            S_DONE:   state_n = S_IDLE;
            S_ERR:    if (abort_i) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (abort_i && in_run) state_n = S_IDLE;
    end

    // Registered outputs, all derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_w_q      <= '0;
            cfg_h_q      <= '0;
            start4_q     <= 1'b0;
            lz77_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= EC_NONE;
            frm_cnt_q    <= '0;
        end else begin
            if (state_q == S_IDLE && start_i) begin
                cfg_w_q <= cfg_w_i;
                cfg_h_q <= cfg_h_i;
            end
            start4_q     <= (state_n == S_LAUNCH);
            lz77_start_q <= (state_q == S_FILT) && (state_n == S_LZ);
            busy_q       <= (state_n == S_CHK) || (state_n == S_LAUNCH) ||
                            (state_n == S_FILT) || (state_n == S_LZ) || (state_n == S_TAIL);
            done_q       <= (state_n == S_DONE);
            err_q        <= (state_n == S_ERR);
            if (state_n == S_ERR) begin
                if (state_q != S_ERR) err_code_q <= code_n;
            end else begin
                err_code_q <= EC_NONE;
            end
            if (state_n == S_DONE) frm_cnt_q <= frm_cnt_q + 16'd1;
        end
    end

    // Sticky completion flags: armed after LAUNCH, cleared on LAUNCH or return to IDLE.
    always_ff @(posedge clk) begin
        if (rst || state_n == S_LAUNCH || state_n == S_IDLE) begin
            lz_flag_q    <= 1'b0;
            bs_flag_q    <= 1'b0;
            adler_flag_q <= 1'b0;
            crc_flag_q   <= 1'b0;
        end else if (in_wait) begin
            lz_flag_q    <= lz_flag_q    | lz77_done_i;
            bs_flag_q    <= bs_flag_q    | bs_done_i;
            adler_flag_q <= adler_flag_q | adler32_done_i;
            crc_flag_q   <= crc_flag_q   | crc32_done_i;
        end
    end

    // Watchdog: restarts on any transition or done event, counts only while waiting.
    always_ff @(posedge clk) begin
        if (rst || state_n != state_q || any_done || !in_wait) wd_q <= '0;
        else                                                   wd_q <= wd_q + 1'b1;
    end

    assign cfg_w_o         = cfg_w_q;
    assign cfg_h_o         = cfg_h_q;
    assign filter_start_o  = start4_q;
    assign adler32_start_o = start4_q;
    assign bs_start_o      = start4_q;
    assign crc32_start_o   = start4_q;
    assign lz77_start_o    = lz77_start_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign err_code_o      = err_code_q;
    assign frm_cnt_o       = frm_cnt_q;

endmodule

// File: tb/tb_png_ctrl.sv
// tb_png_ctrl: table-driven and randomized frame checks for png_ctrl.
// Each frame is described by the cycle (relative to the start pulse) at which
// each done event arrives; the expected end cycle and outcome are either
// hand-entered or derived arithmetically from the sequencing rules.
module tb_png_ctrl;

    localparam int TMO = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i;
    logic [12:0] cfg_w_i, cfg_h_i;
    logic        filter_done_i, lz77_done_i, adler32_done_i, bs_done_i, crc32_done_i;
    logic [12:0] cfg_w_o, cfg_h_o;
    logic        filter_start_o, lz77_start_o, adler32_start_o, bs_start_o, crc32_start_o;
    logic        busy_o, done_o, err_o;
    logic [2:0]  err_code_o;
    logic [15:0] frm_cnt_o;

    png_ctrl #(.W_WD(13), .H_WD(13), .W_MAX(4096), .TMO_WD(24), .TMO_CYC(24'(TMO))) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .cfg_w_i(cfg_w_i), .cfg_h_i(cfg_h_i),
        .filter_done_i(filter_done_i), .lz77_done_i(lz77_done_i),
        .adler32_done_i(adler32_done_i), .bs_done_i(bs_done_i), .crc32_done_i(crc32_done_i),
        .cfg_w_o(cfg_w_o), .cfg_h_o(cfg_h_o),
        .filter_start_o(filter_start_o), .lz77_start_o(lz77_start_o),
        .adler32_start_o(adler32_start_o), .bs_start_o(bs_start_o), .crc32_start_o(crc32_start_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
        .frm_cnt_o(frm_cnt_o)
    );

    always #5 clk = ~clk;

    logic [52:0] obs;
    assign obs = {cfg_w_o, cfg_h_o, filter_start_o, adler32_start_o, bs_start_o, crc32_start_o,
                  lz77_start_o, busy_o, done_o, err_o, err_code_o, frm_cnt_o};

    // Event cycles are relative to the start pulse; -1 means never.
    // ee/ec: expected end cycle and outcome (0 done, 1..4 error code, 7 aborted).
    typedef struct {
        int w, h, f, l, b, a, c, ab;
        bit spam, b2b;
        int ee, ec;
    } vec_t;

    int          n_chk = 0, n_pass = 0;
    logic [15:0] exp_cnt = 16'd0;
    vec_t        tbl[16];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clr_in();
        start_i = 0; abort_i = 0; cfg_w_i = '0; cfg_h_i = '0;
        filter_done_i = 0; lz77_done_i = 0; adler32_done_i = 0; bs_done_i = 0; crc32_done_i = 0;
    endtask

    task automatic check(input string nm, input logic [52:0] got, input logic [52:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    function automatic vec_t mk(int w, int h, int f, int l, int b, int a, int c, int ab,
                                bit spam, bit b2b, int ee, int ec);
        vec_t v;
        v.w = w; v.h = h; v.f = f; v.l = l; v.b = b; v.a = a; v.c = c; v.ab = ab;
        v.spam = spam; v.b2b = b2b; v.ee = ee; v.ec = ec;
        return v;
    endfunction

    // Reference: filter exits at f; lz77 counts once both it and filter are in
    // (LZ exits at f+1 if lz77 came during FILT); done follows the later of the
    // lz exit and bs arrival; a missing event times out TMO cycles after its
    // wait phase opens; abort while busy ends the frame on the next cycle.
    function automatic void model(inout vec_t v);
        int e;
        if (v.w == 0 || v.h == 0 || v.w > 4096) begin v.ee = 2; v.ec = 1; end
        else if (v.f < 0) begin v.ee = 3 + TMO; v.ec = 2; end
        else if (v.l < 0) begin v.ee = v.f + 1 + TMO; v.ec = 3; end
        else begin
            e = (v.l <= v.f) ? v.f + 1 : v.l;
            if (v.b < 0) begin v.ee = e + 1 + TMO; v.ec = 4; end
            else begin v.ee = ((v.b <= e) ? e : v.b) + 1; v.ec = 0; end
        end
        if (v.ab >= 1 && v.ab < v.ee) begin v.ec = 7; v.ee = v.ab + 1; end
    endfunction

    task automatic run_frame(input vec_t v, input int k);
        int te, code, last, spam_end;
        bit s4, lz, busy, dn, er;
        logic [2:0]  ec;
        logic [15:0] cnt;
        te = v.ee; code = v.ec;
        last     = (code == 0 && v.b2b) ? te : te + 1;
        spam_end = (code == 0) ? te : ((code == 7) ? te - 1 : te + 1);
        for (int t = 0; t <= last; t++) begin
            if (t >= 1) begin
                s4   = (t == 2) && (t < te);
                lz   = (v.f >= 0) && (t == v.f + 1) && (t < te);
                busy = (t < te);
                dn   = (code == 0) && (t == te);
                er   = (code >= 1) && (code <= 4) && (t >= te);
                ec   = er ? 3'(code) : 3'd0;
                cnt  = exp_cnt + ((code == 0 && t >= te) ? 16'd1 : 16'd0);
                check($sformatf("frame%0d_t%0d", k, t), obs,
                      {13'(v.w), 13'(v.h), s4, s4, s4, s4, lz, busy, dn, er, ec, cnt});
            end
            clr_in();
            start_i        = (t == 0) || (v.spam && t >= 1 && t <= spam_end);
            cfg_w_i        = (t == 0) ? 13'(v.w) : 13'($urandom);
            cfg_h_i        = (t == 0) ? 13'(v.h) : 13'($urandom);
            filter_done_i  = (t == v.f);
            lz77_done_i    = (t == v.l);
            bs_done_i      = (t == v.b);
            adler32_done_i = (t == v.a);
            crc32_done_i   = (t == v.c);
            abort_i        = (t == v.ab);
            step();
        end
        if (code == 0) exp_cnt = exp_cnt + 16'd1;
        if (code >= 1 && code <= 4) begin
            clr_in();
            abort_i = 1;
            step();
            check($sformatf("frame%0d_abort_clear", k), obs,
                  {13'(v.w), 13'(v.h), 11'd0, exp_cnt});
        end
        clr_in();
    endtask

    initial begin
        vec_t v;
        int k;
        rst = 1; clr_in();
        repeat (3) step();
        check("reset", obs, 53'd0);
        rst = 0;

        //            w     h    f   l   b   a   c   ab spam b2b ee  ec
        tbl[0]  = mk(8,    4,   10, 30, 35, 31, 33, -1, 0, 0, 36, 0); // nominal
        tbl[1]  = mk(8,    4,   10, 12, 5,  -1, 5,  -1, 0, 0, 13, 0); // early bs/crc
        tbl[2]  = mk(0,    4,   -1, -1, -1, -1, -1, -1, 0, 0, 2,  1); // w=0
        tbl[3]  = mk(4097, 4,   -1, -1, -1, -1, -1, -1, 0, 0, 2,  1); // w>W_MAX
        tbl[4]  = mk(4096, 8191, 4, 6,  8,  5,  7,  -1, 0, 1, 9,  0); // w=W_MAX, b2b
        tbl[5]  = mk(5,    0,   -1, -1, -1, -1, -1, -1, 0, 0, 2,  1); // h=0, start after done
        tbl[6]  = mk(20,   20,  6,  6,  9,  -1, -1, -1, 0, 0, 10, 0); // filter+lz77 together
        tbl[7]  = mk(9,    9,   -1, -1, -1, -1, -1, -1, 0, 0, 27, 2); // filter timeout
        tbl[8]  = mk(9,    9,   5,  -1, -1, -1, -1, -1, 0, 0, 30, 3); // lz77 timeout
        tbl[9]  = mk(9,    9,   5,  7,  -1, -1, -1, -1, 0, 0, 32, 4); // bs timeout
        tbl[10] = mk(3,    3,   4,  9,  9,  -1, -1, -1, 0, 0, 10, 0); // lz77+bs same cycle
        tbl[11] = mk(100,  50,  5,  8,  12, 6,  10, -1, 1, 0, 13, 0); // start spam
        tbl[12] = mk(7,    7,   5,  9,  -1, -1, -1, 9,  0, 0, 10, 7); // abort beats lz77 done
        tbl[13] = mk(7,    7,   4,  6,  8,  -1, -1, 9,  0, 0, 9,  0); // abort in DONE ignored
        tbl[14] = mk(0,    2,   -1, -1, -1, -1, -1, -1, 1, 0, 2,  1); // spam during ERR
        tbl[15] = mk(8,    8,   5,  7,  9,  -1, -1, 1,  0, 0, 2,  7); // abort in CHK
        for (int i = 0; i < 16; i++) run_frame(tbl[i], i);

        // Reset landing in TAIL zeroes everything on the next cycle.
        clr_in();
        for (int t = 0; t <= 8; t++) begin
            if (t == 7)
                check("tail_busy", obs, {13'd7, 13'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, exp_cnt});
            clr_in();
            start_i = (t == 0); cfg_w_i = 13'd7; cfg_h_i = 13'd3;
            filter_done_i = (t == 4); lz77_done_i = (t == 6);
            rst = (t == 8);
            step();
        end
        check("rst_in_tail", obs, 53'd0);
        rst = 0; exp_cnt = 16'd0;
        run_frame(mk(11, 12, 3, 4, 5, -1, -1, -1, 0, 0, 6, 0), 100);

        // Randomized frames against the arithmetic reference.
        for (int i = 0; i < 60; i++) begin
            v = mk(1, 1, -1, -1, -1, -1, -1, -1, 0, 0, 0, 0);
            if ($urandom_range(0, 5) == 0) begin
                v.w = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(4097, 8191));
                v.h = int'($urandom_range(1, 8191));
            end else begin
                v.w = int'($urandom_range(1, 4096));
                v.h = int'($urandom_range(1, 8191));
                v.f = int'($urandom_range(3, 12));
                v.l = int'($urandom_range(3, v.f + 10));
                k = (v.l <= v.f) ? v.f + 1 : v.l;
                v.b = int'($urandom_range(3, k + 10));
                model(v);
                v.a = int'($urandom_range(3, v.ee - 1));
                v.c = int'($urandom_range(3, v.ee - 1));
                if ($urandom_range(0, 5) == 0) v.ab = int'($urandom_range(1, v.ee - 1));
                v.b2b = ($urandom_range(0, 1) == 1);
            end
            model(v);
            run_frame(v, 200 + i);
        end

        // Counter wrap: preload the frame count, then two back-to-back frames.
        force dut.frm_cnt_q = 16'hFFFF;
        #2;
        release dut.frm_cnt_q;
        step();
        exp_cnt = 16'hFFFF;
        v = mk(21, 22, 3, 4, 5, -1, -1, -1, 0, 1, 0, 0);
        model(v);
        run_frame(v, 300);
        v = mk(23, 24, 4, 6, 8, -1, -1, -1, 0, 0, 0, 0);
        model(v);
        run_frame(v, 301);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
